// File: rtl/wave_capture_if.sv
// Sample-stream / RAM-write bundle between the audio path, wave_capture and the RAM.
// Inputs to the capture block: new_sample_ready, new_sample_in, wave_display_idle.
// Outputs from the capture block: write_address, write_enable, write_sample, read_index.
interface wave_capture_if #(
  parameter int ADDR_BITS = 8
);
  logic                 new_sample_ready;
  logic [15:0]          new_sample_in;
  logic                 wave_display_idle;
  logic [ADDR_BITS:0]   write_address;
  logic                 write_enable;
  logic [7:0]           write_sample;
  logic                 read_index;

  // Driver side: produces samples and the display idle flag, observes the RAM port.
  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  // Capture block side.
  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Writer side of the double-buffered waveform RAM: triggers on a rising zero crossing,
// captures 2^ADDR_BITS samples into the half not displayed, then flips read_index once
// the display is idle. Latency: one cycle from strobe to write. No backpressure; every strobe is consumed.
// Ports: clk, reset (sync, active-high); bus.slave carries the sample strobe/data,
// the display idle flag, and the registered RAM write port plus read_index.
module wave_capture #(
  parameter int ADDR_BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  wave_capture_if.slave   bus
);

  localparam logic [1:0] ARMED  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] offset;
  logic [15:0]          prev_sample;
  logic                 read_index;
  logic                 write_enable;
  logic [ADDR_BITS:0]   write_address;
  logic [7:0]           write_sample;

  logic       crossing;
  logic [7:0] sample_u8;

  // Rising zero crossing: previous sample negative, current one non-negative.
  assign crossing  = prev_sample[15] & ~bus.new_sample_in[15];
  // Flipping the sign bit turns the signed top byte into an offset-binary byte.
  assign sample_u8 = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARMED;
      offset        <= '0;
      prev_sample   <= 16'h0000;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= 8'h00;
    end else begin
      write_enable <= 1'b0;
      if (bus.new_sample_ready) begin
        prev_sample <= bus.new_sample_in;
      end

      case (state)
        ARMED: begin
          if (bus.new_sample_ready && crossing) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, {ADDR_BITS{1'b0}}};
            write_sample  <= sample_u8;
            offset        <= {{(ADDR_BITS-1){1'b0}}, 1'b1};
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, offset};
            write_sample  <= sample_u8;
            // Offset wraps to 0 naturally after the last slot.
            offset        <= offset + 1'b1;
            if (offset == {ADDR_BITS{1'b1}}) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // The half just filled becomes visible only while the display is not reading.
          if (bus.wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign bus.write_enable  = write_enable;
  assign bus.write_address = write_address;
  assign bus.write_sample  = write_sample;
  assign bus.read_index    = read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: vector table for reset and the first trigger,
// then hand-written sequences for full capture, WAIT hold, buffer flip and mid-capture reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_wave_capture;
  localparam int AB = 8;
  localparam int NS = 1 << AB;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  wave_capture_if #(.ADDR_BITS(AB)) bus ();

  wave_capture #(.ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] smp;
    logic        idle;
    logic        exp_we;
    logic        chk_dat;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_ws;
    logic        exp_ri;
  } vec_t;

  vec_t vecs [10];

  // Expected byte from arithmetic: top byte of the signed sample shifted into 0..255.
  function automatic logic [7:0] exp_ws(input logic [15:0] s);
    int v;
    v = $signed(s) >>> 8;
    return 8'(v + 128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single strobe followed by a check of the registered write port.
  task automatic strobe(input logic [15:0] s, input logic we, input logic [8:0] addr, input string name);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = s;
    tick();
    bus.new_sample_ready = 1'b0;
    chk({name, "_we"}, 32'(bus.write_enable), 32'(we));
    if (we) begin
      chk({name, "_addr"}, 32'(bus.write_address), 32'(addr));
      chk({name, "_ws"},   32'(bus.write_sample),  32'(exp_ws(s)));
    end
  endtask

  // Back-to-back strobes at offsets first..first+n-1 of the given half.
  task automatic run_samples(input int first, input int n, input logic half);
    logic [15:0] s;
    for (int j = first; j < first + n; j++) begin
      s = 16'(j * 16'h0123 + 16'h0100);
      bus.new_sample_ready = 1'b1;
      bus.new_sample_in    = s;
      tick();
      chk("cap_we",   32'(bus.write_enable),  32'd1);
      chk("cap_addr", 32'(bus.write_address), 32'({half, 8'(j)}));
      chk("cap_ws",   32'(bus.write_sample),  32'(exp_ws(s)));
    end
    bus.new_sample_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 16'h0000;
    bus.wave_display_idle = 1'b0;

    //          rst  rdy  smp       idle  we   dat  addr     ws     ri
    vecs[0] = '{1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 9'h000, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 9'h100, 8'h81, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b1, 9'h101, 8'h82, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0};

    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      reset                 = vecs[i].rst;
      bus.new_sample_ready  = vecs[i].rdy;
      bus.new_sample_in     = vecs[i].smp;
      bus.wave_display_idle = vecs[i].idle;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(bus.write_enable), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_ri", i), 32'(bus.read_index),   32'(vecs[i].exp_ri));
      if (vecs[i].chk_dat) begin
        chk($sformatf("vec%0d_addr", i), 32'(bus.write_address), 32'(vecs[i].exp_addr));
        chk($sformatf("vec%0d_ws", i),   32'(bus.write_sample),  32'(vecs[i].exp_ws));
      end
    end
    reset                 = 1'b0;
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;

    // Rest of the first capture: offsets 2..255 back-to-back into half 1.
    run_samples(2, NS - 2, 1'b1);
    tick();
    chk("after_full_we", 32'(bus.write_enable), 32'd0);
    chk("after_full_ri", 32'(bus.read_index),   32'd0);

    // WAIT with display busy: strobes including crossings produce no writes.
    for (int c = 0; c < 50; c++) begin
      s = c[0] ? 16'h0100 : 16'h8000;
      bus.new_sample_ready = c[1];
      bus.new_sample_in    = s;
      tick();
      chk("wait_we", 32'(bus.write_enable), 32'd0);
      chk("wait_ri", 32'(bus.read_index),   32'd0);
    end
    bus.new_sample_ready = 1'b0;

    // One idle cycle flips the displayed half.
    bus.wave_display_idle = 1'b1;
    tick();
    bus.wave_display_idle = 1'b0;
    chk("flip_ri", 32'(bus.read_index),   32'd1);
    chk("flip_we", 32'(bus.write_enable), 32'd0);

    // -1 then 0 triggers into half 0; idle is ignored while capturing.
    strobe(16'hFFFF, 1'b0, 9'h000, "neg1");
    bus.wave_display_idle = 1'b1;
    strobe(16'h0000, 1'b1, 9'h000, "zero_trig");
    bus.wave_display_idle = 1'b0;
    chk("zero_trig_ws80", 32'(bus.write_sample), 32'h80);
    run_samples(1, 99, 1'b0);

    // Reset mid-capture: partial buffer abandoned, read_index forced back to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_we",   32'(bus.write_enable),  32'd0);
    chk("rst_ri",   32'(bus.read_index),    32'd0);
    chk("rst_addr", 32'(bus.write_address), 32'd0);
    chk("rst_ws",   32'(bus.write_sample),  32'd0);

    // Fresh crossing restarts at offset 0 of half 1, then fills the whole half.
    strobe(16'h8000, 1'b0, 9'h000, "re_neg");
    strobe(16'h0100, 1'b1, 9'h100, "re_trig");
    run_samples(1, NS - 1, 1'b1);
    tick();
    chk("re_done_we", 32'(bus.write_enable), 32'd0);

    // A strobe on the WAIT->ARMED edge is not a trigger but does update prev_sample.
    strobe(16'h8000, 1'b0, 9'h000, "edge_neg");
    bus.wave_display_idle = 1'b1;
    strobe(16'h0000, 1'b0, 9'h000, "edge_same");
    bus.wave_display_idle = 1'b0;
    chk("edge_ri", 32'(bus.read_index), 32'd1);
    strobe(16'h0100, 1'b0, 9'h000, "edge_after");
    strobe(16'h8001, 1'b0, 9'h000, "edge_neg2");
    strobe(16'h7FFF, 1'b1, 9'h000, "edge_trig");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
